// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   Sequencer and round-key store for AES-128 key expansion. A cipher key is
//   accepted over valid/ready, the external KeyTotal generator is stepped through
//   rounds 1..10 (KG_LAT extra cycles per round), and all 11 round keys are kept
//   in a register file with a registered, 1-cycle-latency read port.
//   Optional feature macro: KEYSCHED_ZEROIZE_EN -- when defined, round keys 1..10
//   are cleared on every key acceptance so a previous schedule is never readable.
module aes_key_sched_ctrl #(
  parameter int KG_LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] kg_key,
  output logic [3:0]   kg_times,
  input  logic [127:0] kg_keyout,
  output logic         busy,
  output logic         sched_done,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         rk_valid
);

  localparam int              WAIT_W     = (KG_LAT > 0) ? $clog2(KG_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(KG_LAT);
  localparam logic [3:0]      LAST_ROUND = 4'd10;
  localparam logic [3:0]      LAST_ADDR  = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          round;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [127:0]        cur;
  logic [127:0]        store [0:10];

  logic                accept;
  logic                capture;
  logic                rd_in_range;
  logic                rd_written;

  // Handshake and capture strobes; key_ready is only high in IDLE/DONE
  assign accept  = key_valid & key_ready;
  assign capture = (state == EXPAND) && (wait_cnt == WAIT_LAST);

  // KeyTotal is driven straight from the registered schedule state
  assign kg_key   = (state == EXPAND) ? cur   : '0;
  assign kg_times = (state == EXPAND) ? round : 4'd0;

  // An entry belongs to the current schedule once its round has been captured;
  // anything read on the accept edge still belongs to the outgoing schedule
  assign rd_in_range = (rk_addr <= LAST_ADDR);
  assign rd_written  = !accept && ((rk_addr < round) || (state == DONE));

  // Sequencer: key acceptance, per-round wait, round capture and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= 4'd0;
      wait_cnt   <= '0;
      cur        <= '0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      sched_done <= 1'b0;
    end else if (accept) begin
      state      <= EXPAND;
      cur        <= key_in;
      round      <= 4'd1;
      wait_cnt   <= '0;
      key_ready  <= 1'b0;
      busy       <= 1'b1;
      sched_done <= 1'b0;
    end else if (state == EXPAND) begin
      if (capture) begin
        cur      <= kg_keyout;
        round    <= round + 4'd1;
        wait_cnt <= '0;
        if (round == LAST_ROUND) begin
          state      <= DONE;
          key_ready  <= 1'b1;
          busy       <= 1'b0;
          sched_done <= 1'b1;
        end
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Round-key register file: key 0 on acceptance, key N on the capture of round N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) begin
        store[i] <= '0;
      end
    end else if (accept) begin
      store[0] <= key_in;
`ifdef KEYSCHED_ZEROIZE_EN
      for (int i = 1; i < 11; i++) begin
        store[i] <= '0;
      end
`endif
    end else if (capture && (round <= LAST_ROUND)) begin
      store[round] <= kg_keyout;
    end
  end

  // Registered read port; out-of-range addresses return zero and invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data  <= '0;
      rk_valid <= 1'b0;
    end else if (rk_rd_en) begin
      if (rd_in_range) begin
        rk_data  <= store[rk_addr];
        rk_valid <= rd_written;
      end else begin
        rk_data  <= '0;
        rk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl
//   Two instances: KG_LAT=0 (scoreboarded against a schedule-level model) and
//   KG_LAT=2 (directed timing). A behavioural FIPS-197 round function stands in
//   for KeyTotal. Honours KEYSCHED_ZEROIZE_EN in the reference model.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] key_in, kg_key, kg_keyout, rk_data;
  logic         key_valid, key_ready, busy, sched_done, rk_rd_en, rk_valid;
  logic [3:0]   kg_times, rk_addr;

  logic [127:0] key_in2, kg_key2, kg_keyout2, rk_data2;
  logic         key_valid2, key_ready2, busy2, sched_done2, rk_rd_en2, rk_valid2;
  logic [3:0]   kg_times2, rk_addr2;

  int errors = 0;
  int checks = 0;

  // ---------------- FIPS-197 arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] t);
    logic [7:0] r = 8'h01;
    for (int i = 1; i < int'(t); i++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [3:0] t);
    logic [31:0] w0, w1, w2, w3, rw, tmp, n0, n1, n2, n3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rw = {w3[23:0], w3[31:24]};
    tmp = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])} ^ {rcon(t), 24'h0};
    n0 = w0 ^ tmp; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // KeyTotal stand-ins (combinational)
  assign kg_keyout  = next_rk(kg_key, kg_times);
  assign kg_keyout2 = next_rk(kg_key2, kg_times2);

  aes_key_sched_ctrl #(.KG_LAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .kg_key(kg_key), .kg_times(kg_times), .kg_keyout(kg_keyout), .busy(busy),
    .sched_done(sched_done), .rk_rd_en(rk_rd_en), .rk_addr(rk_addr), .rk_data(rk_data),
    .rk_valid(rk_valid));

  aes_key_sched_ctrl #(.KG_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in2), .key_valid(key_valid2), .key_ready(key_ready2),
    .kg_key(kg_key2), .kg_times(kg_times2), .kg_keyout(kg_keyout2), .busy(busy2),
    .sched_done(sched_done2), .rk_rd_en(rk_rd_en2), .rk_addr(rk_addr2), .rk_data(rk_data2),
    .rk_valid(rk_valid2));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model for dut (KG_LAT=0) ----------------
  typedef struct {
    logic [127:0] d;
    logic         v;
  } rd_t;

  rd_t          sbq[$];
  rd_t          m_r, m_p;
  logic [127:0] m_key [0:10];
  logic [127:0] m_sched [0:10];
  int           m_written = 0;
  int           m_cyc = 0;
  logic         m_ready = 1'b1;
  logic         m_acc_now;
  int           m_acc = 0;

  // Schedule-level model: key N of the precomputed schedule appears N*(LAT+1) edges after accept
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) m_key[i] = '0;
      m_written = 0;
      m_cyc = 0;
      m_ready = 1'b1;
      sbq.delete();
    end else begin
      m_acc_now = key_valid && m_ready;
      if (rk_rd_en) begin
        m_r.d = (rk_addr <= 4'd10) ? m_key[rk_addr] : '0;
        m_r.v = !m_acc_now && (rk_addr <= 4'd10) && (int'(rk_addr) < m_written);
        sbq.push_back(m_r);
      end
      if (m_acc_now) begin
        m_sched[0] = key_in;
        for (int i = 1; i < 11; i++) m_sched[i] = next_rk(m_sched[i-1], 4'(i));
        m_key[0] = key_in;
`ifdef KEYSCHED_ZEROIZE_EN
        for (int i = 1; i < 11; i++) m_key[i] = '0;
`endif
        m_written = 1;
        m_cyc = 0;
        m_ready = 1'b0;
        m_acc++;
      end else if (m_written >= 1 && m_written <= 10) begin
        m_cyc++;
        if (m_cyc % 1 == 0) begin
          m_key[m_written] = m_sched[m_written];
          m_written++;
          if (m_written == 11) m_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: drain read results and compare control outputs every cycle
  always @(negedge clk) begin
    logic exp_busy;
    while (sbq.size() > 0) begin
      m_p = sbq.pop_front();
      chk("sb_rk_data", rk_data, m_p.d);
      chk("sb_rk_valid", 128'(rk_valid), 128'(m_p.v));
    end
    exp_busy = (m_written >= 1) && (m_written <= 10);
    chk("mon_key_ready", 128'(key_ready), 128'(m_ready));
    chk("mon_busy", 128'(busy), 128'(exp_busy));
    chk("mon_sched_done", 128'(sched_done), 128'(m_written == 11));
    chk("mon_kg_times", 128'(kg_times), exp_busy ? 128'(m_written) : 128'd0);
    chk("mon_kg_key", kg_key, exp_busy ? m_key[m_written-1] : 128'd0);
  end

  // ---------------- stimulus helpers ----------------
  int tcount[16];

  task automatic wait_accept(input int a0);
    int n = 0;
    while (m_acc == a0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (m_acc == a0) chk("accept_timeout", 128'd0, 128'd1);
  endtask

  // Offer a key, wait for acceptance, then count cycles to sched_done
  task automatic send_key(input logic [127:0] k, output int lat);
    int a0;
    a0 = m_acc;
    key_in = k;
    key_valid = 1'b1;
    wait_accept(a0);
    key_valid = 1'b0;
    for (int i = 0; i < 16; i++) tcount[i] = 0;
    lat = 0;
    while (!sched_done && lat < 200) begin
      tcount[kg_times]++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic rd(input logic [3:0] a);
    rk_rd_en = 1'b1;
    rk_addr = a;
    @(negedge clk);
    rk_rd_en = 1'b0;
  endtask

  task automatic rd2(input logic [3:0] a);
    rk_rd_en2 = 1'b1;
    rk_addr2 = a;
    @(negedge clk);
    rk_rd_en2 = 1'b0;
  endtask

  initial begin
    int lat, n, a0;
    logic [127:0] ka, kb, exp6;
    rst_n = 1'b0;
    key_in = '0; key_valid = 1'b0; rk_rd_en = 1'b0; rk_addr = '0;
    key_in2 = '0; key_valid2 = 1'b0; rk_rd_en2 = 1'b0; rk_addr2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_sched_done", 128'(sched_done), 128'd0);
    chk("rst_rk_data", rk_data, 128'd0);
    chk("rst_rk_valid", 128'(rk_valid), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: FIPS-197 key
    send_key(FIPS_KEY, lat);
    chk("t1_latency", 128'(lat), 128'd10);
    for (int v = 1; v <= 10; v++) chk("t1_kg_times_once", 128'(tcount[v]), 128'd1);
    rd(4'd1);
    chk("t1_rk1", rk_data, FIPS_RK1);
    chk("t1_rk1_valid", 128'(rk_valid), 128'd1);
    rd(4'd10);
    chk("t1_rk10", rk_data, FIPS_RK10);
    chk("t1_rk10_valid", 128'(rk_valid), 128'd1);

    // Test 2: second key held during expansion
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    a0 = m_acc;
    key_in = ka;
    key_valid = 1'b1;
    wait_accept(a0);
    key_in = kb;
    a0 = m_acc;
    n = 0;
    while (m_acc == a0 && n < 200) begin
      if (n < 10) chk("t2_ready_low", 128'(key_ready), 128'd0);
      @(negedge clk);
      n++;
    end
    chk("t2_accept_cycles", 128'(n), 128'd11);
    key_valid = 1'b0;
    n = 0;
    while (!sched_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    rd(4'd0);
    chk("t2_rk0_second", rk_data, kb);
    chk("t2_rk0_valid", 128'(rk_valid), 128'd1);

    // Test 3: read ahead of the expansion, then an out-of-range address
    a0 = m_acc;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    wait_accept(a0);
    key_valid = 1'b0;
    n = 0;
    while (kg_times != 4'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    rd(4'd5);
    chk("t3_rk5_valid", 128'(rk_valid), 128'd0);
    n = 0;
    while (!sched_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    rd(4'd12);
    chk("t3_rk12_data", rk_data, 128'd0);
    chk("t3_rk12_valid", 128'(rk_valid), 128'd0);

    // Test 4: reset at round 6, then reload the FIPS key
    a0 = m_acc;
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    wait_accept(a0);
    key_valid = 1'b0;
    n = 0;
    while (kg_times != 4'd6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t4_key_ready", 128'(key_ready), 128'd1);
    chk("t4_busy", 128'(busy), 128'd0);
    chk("t4_sched_done", 128'(sched_done), 128'd0);
    chk("t4_kg_times", 128'(kg_times), 128'd0);
    chk("t4_kg_key", kg_key, 128'd0);
    chk("t4_rk_data", rk_data, 128'd0);
    chk("t4_rk_valid", 128'(rk_valid), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_done_before_reload", 128'(sched_done), 128'd0);
    rd(4'd0);
    chk("t4_rk0_invalid", 128'(rk_valid), 128'd0);
    send_key(FIPS_KEY, lat);
    chk("t4_latency", 128'(lat), 128'd10);
    rd(4'd10);
    chk("t4_rk10", rk_data, FIPS_RK10);

    // Test 6: reload in DONE, read rk[10] one cycle later
    a0 = m_acc;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    wait_accept(a0);
    key_valid = 1'b0;
    rd(4'd10);
`ifdef KEYSCHED_ZEROIZE_EN
    exp6 = 128'd0;
`else
    exp6 = FIPS_RK10;
`endif
    chk("t6_rk10_data", rk_data, exp6);
    chk("t6_rk10_valid", 128'(rk_valid), 128'd0);
    n = 0;
    while (!sched_done && n < 200) begin
      @(negedge clk);
      n++;
    end

    // Test 5: KG_LAT=2 instance
    key_in2 = FIPS_KEY;
    key_valid2 = 1'b1;
    @(negedge clk);
    key_valid2 = 1'b0;
    chk("t5_busy", 128'(busy2), 128'd1);
    for (int i = 0; i < 16; i++) tcount[i] = 0;
    lat = 0;
    while (!sched_done2 && lat < 300) begin
      tcount[kg_times2]++;
      @(negedge clk);
      lat++;
    end
    chk("t5_latency", 128'(lat), 128'd30);
    for (int v = 1; v <= 10; v++) chk("t5_kg_times_3cyc", 128'(tcount[v]), 128'd3);
    rd2(4'd1);
    chk("t5_rk1", rk_data2, FIPS_RK1);
    rd2(4'd10);
    chk("t5_rk10", rk_data2, FIPS_RK10);
    chk("t5_rk10_valid", 128'(rk_valid2), 128'd1);

    // Randomised traffic against the scoreboard
    a0 = m_acc;
    for (int c = 0; c < 800; c++) begin
      if (key_valid && m_acc != a0) key_valid = 1'b0;
      a0 = m_acc;
      if (!key_valid && ($urandom % 20 == 0)) begin
        key_in = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
      end
      rk_rd_en = ($urandom % 2) == 1;
      rk_addr = 4'($urandom % 16);
      @(negedge clk);
    end
    key_valid = 1'b0;
    rk_rd_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
